uart_rx_ext: RTL and testbench
==============================

UART_RX_EXT -- requirements
Module: uart_rx_ext

Interface
- REQ-001 Parameter CLK_FREQ, default 125000000: input clock frequency in Hz.
- REQ-002 Parameter BAUD_RATE, default 115200: serial bit rate in bits/s.
- REQ-003 Parameter OVERSAMPLE, default 16: sample ticks per bit; legal values 8 or 16.
- REQ-004 Parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
- REQ-005 Parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
- REQ-006 Parameter STOP_BITS, default 1: number of stop bits checked; legal values 1 or 2.
- REQ-007 clk  input  1: single clock for the whole block.
- REQ-008 reset  input  1: reset is asynchronous and active-high.
- REQ-009 rx  input  1: asynchronous serial line; idles high.
- REQ-010 rx_data  output  DATA_BITS: received word, LSB = first bit on the line.
- REQ-011 rx_valid  output  1: rx_data and the error flags are valid.
- REQ-012 rx_ready  input  1: consumer accepts the word; transfer happens when rx_valid && rx_ready.
- REQ-013 parity_err  output  1: parity mismatch for the held word; forced 0 when PARITY=0.
- REQ-014 frame_err  output  1: any checked stop bit was sampled 0 for the held word.
- REQ-015 overrun  output  1: one-cycle pulse when a completed frame is dropped.

Function
- REQ-016 rx passes through a 2-flop synchroniser, reset value 1; all logic uses the synchronised signal (rx_s).
- REQ-017 Tick generator: counter of width $clog2(DIV)+1, with DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) - 1.
  - Counter pulses tick for one clk when it reaches DIV, then wraps to 0.
  - Counter is held at 0 in IDLE.
  - DIV = 0 means tick every clk.
- REQ-018 A sample counter (0..OVERSAMPLE-1) advances on each tick. Bit value = majority of rx_s at sample indices M-1, M, M+1, with M = OVERSAMPLE/2. The bit decision occurs at index M+1.
- REQ-019 FSM states are IDLE, START, DATA, PARITY, STOP. Encoding is free; the state register resets to IDLE.
- REQ-020 IDLE -> START on a falling edge of rx_s (previous rx_s 1, current 0). The sample counter and tick counter are cleared on entry.
- REQ-021 START, at the decision point:
  - majority 0 -> DATA, bit index cleared;
  - majority 1 -> IDLE (false start, nothing reported).
- REQ-022 DATA: one bit is decided per bit period and shifted in LSB-first. After DATA_BITS bits -> PARITY if PARITY != 0, else STOP.
- REQ-023 PARITY: the decided bit is compared with the expected bit.
  - Odd parity: XOR of data bits and parity bit must be 1.
  - Even parity: that XOR must be 0.
  - A mismatch latches the internal parity error.
- REQ-024 STOP: each of STOP_BITS stop bits is decided. Any 0 latches the internal frame error.
- REQ-025 At the decision point of the last stop bit the frame is complete, and the FSM returns to IDLE in the same cycle. No wait for the end of the stop bit, so back-to-back frames are received.
- REQ-026 Output register, with completion at clock edge N:
  - If rx_valid is 0, or rx_valid && rx_ready at edge N, then from edge N rx_data, parity_err, frame_err load and rx_valid = 1.
  - Otherwise the frame is dropped, the held word is unchanged, and overrun = 1 for exactly one cycle.
- REQ-027 rx_valid deasserts on the edge after rx_valid && rx_ready, unless a new frame completes on that same edge (REQ-026 takes priority).
- REQ-028 rx_data, parity_err and frame_err are stable while rx_valid = 1 and rx_ready = 0.
- REQ-029 A frame with a framing or parity error is still delivered, with its flag set. Error flags never assert while rx_valid = 0.
- REQ-030 rx_ready is ignored while rx_valid = 0.

Reset
- REQ-031 Asserting reset asynchronously forces the following values, including mid-frame:
  - FSM = IDLE; tick, sample and bit counters = 0; shift register = 0;
  - rx_data = 0; rx_valid = 0; parity_err = 0; frame_err = 0; overrun = 0;
  - synchroniser flops = 1.
- REQ-032 A frame in progress when reset asserts is discarded. After reset deasserts, reception restarts only on a new falling edge of rx_s.

Verification (CLK_FREQ=16000000, BAUD_RATE=1000000, OVERSAMPLE=16, so DIV=0 and 16 clk per bit)
- REQ-033 Nominal frame: DATA_BITS=8, PARITY=0, STOP_BITS=1; send 0xA5 with rx_ready=1.
  - rx_data=0xA5, rx_valid high 1 cycle, parity_err=0, frame_err=0.
- REQ-034 Parity: PARITY=2 (even); send 0x03 with parity bit 1 -> parity_err=1, rx_data=0x03. Repeat with parity bit 0 -> parity_err=0.
- REQ-035 Framing and false start:
  - 0x55 with stop bit 0 -> frame_err=1, word delivered.
  - A 5-clk low glitch on idle rx -> no rx_valid, FSM back in IDLE.
- REQ-036 Overrun: rx_ready=0; send 0x11 then 0x22 back-to-back.
  - rx_data stays 0x11, rx_valid stays 1, overrun pulses 1 cycle at the second completion.
  - rx_ready=1 -> rx_valid falls next cycle.
- REQ-037 Noise and config: DATA_BITS=7, STOP_BITS=2; send 0x3C with a 1-clk inverted glitch at sample M of each bit.
  - rx_data=0x3C (majority vote).
  - Second stop bit 0 -> frame_err=1.
- REQ-038 Reset mid-frame: assert reset at data bit 4 of 0xF0.
  - All outputs 0 immediately (asynchronous), no word delivered.
  - The next frame 0x0F is received correctly.

Source files
------------

// File: rtl/uart_rx_ext.sv
// uart_rx_ext: oversampling UART receiver with majority-vote bits, parity/stop checks and a held output word
module uart_rx_ext #(
  parameter int CLK_FREQ   = 125000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);
  localparam int DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE) - 1;
  localparam int CW = $clog2(DIV) + 1;
  localparam int SW = $clog2(OVERSAMPLE);
  localparam int M = OVERSAMPLE / 2;
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic ODD = (PARITY == 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
  state_t r_state, w_next;
  logic [1:0] r_sync;
  logic r_rx_d, r_s1, r_s2, r_perr, r_ferr;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_samp;
  logic [BW-1:0] r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic w_rx_s, w_tick, w_dec, w_maj, w_last_data, w_last_stop, w_done, w_par_bad;
  assign w_rx_s = r_sync[1];
  assign w_tick = (r_state != S_IDLE) && (r_cnt == CW'(DIV));
  assign w_dec = w_tick && (r_samp == SW'(M + 1));
  assign w_maj = (r_s1 & r_s2) | (r_s1 & w_rx_s) | (r_s2 & w_rx_s);
  assign w_last_data = r_bit == BW'(DATA_BITS - 1);
  assign w_last_stop = r_bit == BW'(STOP_BITS - 1);
  assign w_done = (r_state == S_STOP) && w_dec && w_last_stop;
  assign w_par_bad = ^r_shift ^ w_maj ^ ODD;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = (r_rx_d && !w_rx_s) ? S_START : S_IDLE;
      S_START: w_next = w_dec ? (w_maj ? S_IDLE : S_DATA) : S_START;
      S_DATA:  w_next = (w_dec && w_last_data) ? ((PARITY != 0) ? S_PAR : S_STOP) : S_DATA;
      S_PAR:   w_next = w_dec ? S_STOP : S_PAR;
      S_STOP:  w_next = w_done ? S_IDLE : S_STOP;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync <= 2'b11;
      r_rx_d <= 1'b1;
      r_cnt <= '0;
      r_samp <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_perr <= 1'b0;
      r_ferr <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], rx};
      r_rx_d <= w_rx_s;
      r_cnt <= (r_state == S_IDLE || w_tick) ? '0 : r_cnt + CW'(1);
      r_samp <= (r_state == S_IDLE) ? '0 : w_tick ? r_samp + SW'(1) : r_samp;
      if (w_tick && r_samp == SW'(M - 1)) r_s1 <= w_rx_s;
      if (w_tick && r_samp == SW'(M)) r_s2 <= w_rx_s;
      if (r_state == S_IDLE) r_bit <= '0;
      else if (w_dec && (r_state == S_DATA || r_state == S_STOP))
        r_bit <= (r_state == S_DATA && w_last_data) ? '0 : r_bit + BW'(1);
      if (w_dec && r_state == S_DATA) r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
      if (r_state == S_IDLE) r_perr <= 1'b0;
      else if (w_dec && r_state == S_PAR && w_par_bad) r_perr <= 1'b1;
      if (r_state == S_IDLE) r_ferr <= 1'b0;
      else if (w_dec && r_state == S_STOP && !w_maj) r_ferr <= 1'b1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= w_done && rx_valid && !rx_ready;
      if (w_done && (!rx_valid || rx_ready)) begin
        rx_data <= r_shift;
        parity_err <= r_perr;
        frame_err <= r_ferr | ~w_maj;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
        parity_err <= 1'b0;
        frame_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_ext.sv
// tb_uart_rx_ext: directed and random frames on four receiver configurations, checked against a frame-level model
`timescale 1ns/1ps
module tb_uart_rx_ext;
  localparam int CF = 16000000;
  localparam int BR = 1000000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] rxl = 4'hF;
  logic [3:0] rdy = 4'hF;
  logic [3:0] vl, pe, fe, ov;
  logic [7:0] d0, d1;
  logic [6:0] d2;
  logic [8:0] d3;
  int n_cmp = 0;
  int n_bad = 0;
  int vcyc[4] = '{default: 0};
  int ocyc[4] = '{default: 0};
  logic [8:0] cd[4];
  logic cpe[4], cfe[4];
  int nd[4] = '{8, 8, 7, 9};
  int par[4] = '{0, 2, 0, 1};
  int ns[4] = '{1, 1, 2, 1};

  always #5 clk = ~clk;

  uart_rx_ext #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .reset(reset), .rx(rxl[0]), .rx_data(d0), .rx_valid(vl[0]), .rx_ready(rdy[0]),
    .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]));
  uart_rx_ext #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .reset(reset), .rx(rxl[1]), .rx_data(d1), .rx_valid(vl[1]), .rx_ready(rdy[1]),
    .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]));
  uart_rx_ext #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u2 (
    .clk(clk), .reset(reset), .rx(rxl[2]), .rx_data(d2), .rx_valid(vl[2]), .rx_ready(rdy[2]),
    .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]));
  uart_rx_ext #(.CLK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(16), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u3 (
    .clk(clk), .reset(reset), .rx(rxl[3]), .rx_data(d3), .rx_valid(vl[3]), .rx_ready(rdy[3]),
    .parity_err(pe[3]), .frame_err(fe[3]), .overrun(ov[3]));

  function automatic logic [8:0] dat(input int i);
    return (i == 0) ? {1'b0, d0} : (i == 1) ? {1'b0, d1} : (i == 2) ? {2'b0, d2} : d3;
  endfunction

  always @(negedge clk)
    for (int i = 0; i < 4; i++) begin
      if (vl[i]) begin
        vcyc[i]++;
        cd[i] = dat(i);
        cpe[i] = pe[i];
        cfe[i] = fe[i];
      end
      if (ov[i]) ocyc[i]++;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] m_data(input int ln, input logic [8:0] d);
    return d & ((9'h1 << nd[ln]) - 9'h1);
  endfunction

  function automatic logic m_pe(input int ln, input logic [8:0] d, input logic p);
    int ones = $countones(m_data(ln, d)) + int'(p);
    if (par[ln] == 0) return 1'b0;
    return (par[ln] == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
  endfunction

  function automatic logic m_fe(input int ln, input logic [1:0] st);
    return (ns[ln] == 1) ? !st[0] : !(st[0] && st[1]);
  endfunction

  task automatic drive_bit(input int ln, input logic b, input bit gl);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      rxl[ln] = (gl && k == 9) ? ~b : b;
    end
  endtask

  task automatic idle(input int ln, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rxl[ln] = 1'b1;
    end
  endtask

  task automatic send(input int ln, input logic [8:0] d, input logic p, input logic [1:0] st, input bit gl);
    drive_bit(ln, 1'b0, gl);
    for (int i = 0; i < nd[ln]; i++) drive_bit(ln, d[i], gl);
    if (par[ln] != 0) drive_bit(ln, p, gl);
    for (int i = 0; i < ns[ln]; i++) drive_bit(ln, st[i], gl);
  endtask

  task automatic run(input int ln, input logic [8:0] d, input logic p, input logic [1:0] st, input bit gl, input string tag);
    int v = vcyc[ln];
    send(ln, d, p, st, gl);
    idle(ln, 24);
    chk({tag, "_vcycles"}, vcyc[ln] - v, 1);
    chk({tag, "_data"}, cd[ln], m_data(ln, d));
    chk({tag, "_perr"}, cpe[ln], m_pe(ln, d, p));
    chk({tag, "_ferr"}, cfe[ln], m_fe(ln, st));
    chk({tag, "_idle"}, {vl[ln], pe[ln], fe[ln]}, 0);
  endtask

  initial begin
    int v, o, ln;
    logic [8:0] rd;
    logic rp;
    logic [1:0] rs;
    bit rg;
    repeat (3) @(negedge clk);
    chk("rst_valid", vl, 0);
    chk("rst_data", {d0, d1, d2, d3}, 0);
    chk("rst_flags", {pe, fe, ov}, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    run(0, 9'h0A5, 1'b0, 2'b11, 1'b0, "nominal");
    run(1, 9'h003, 1'b1, 2'b11, 1'b0, "par_bad");
    run(1, 9'h003, 1'b0, 2'b11, 1'b0, "par_ok");
    run(0, 9'h055, 1'b0, 2'b10, 1'b0, "stop_bad");

    v = vcyc[0];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rxl[0] = 1'b0;
    end
    idle(0, 40);
    chk("false_start_vcycles", vcyc[0] - v, 0);
    run(0, 9'h03C, 1'b0, 2'b11, 1'b0, "after_glitch");

    rdy[0] = 1'b0;
    v = vcyc[0];
    o = ocyc[0];
    send(0, 9'h011, 1'b0, 2'b11, 1'b0);
    send(0, 9'h022, 1'b0, 2'b11, 1'b0);
    idle(0, 24);
    chk("ovr_data", d0, 8'h11);
    chk("ovr_valid", vl[0], 1'b1);
    chk("ovr_pulses", ocyc[0] - o, 1);
    @(negedge clk);
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("ovr_release", vl[0], 1'b0);

    run(2, 9'h03C, 1'b0, 2'b11, 1'b1, "noise");
    run(2, 9'h03C, 1'b0, 2'b01, 1'b1, "stop2_bad");

    rdy[0] = 1'b0;
    send(0, 9'h05A, 1'b0, 2'b11, 1'b0);
    idle(0, 24);
    chk("held_before_rst", {vl[0], d0}, {1'b1, 8'h5A});
    drive_bit(0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive_bit(0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      rxl[0] = 1'b1;
    end
    #2 reset = 1'b1;
    #1 chk("async_rst_outs", {d0, vl[0], pe[0], fe[0], ov[0]}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rdy[0] = 1'b1;
    v = vcyc[0];
    idle(0, 40);
    chk("post_rst_quiet", {vcyc[0] - v, 31'(vl[0])}, 0);
    run(0, 9'h00F, 1'b0, 2'b11, 1'b0, "post_rst");

    for (int t = 0; t < 24; t++) begin
      ln = int'($urandom_range(0, 3));
      rd = 9'($urandom);
      rp = 1'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      rg = 1'($urandom);
      run(ln, rd, rp, rs, rg, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
